reaction_timer_multi: RTL and testbench
=======================================

// Module: reaction_timer_multi
// PURPOSE
//  Parametrised multi-round reaction-time engine: random pre-delay, GO lamp, BCD
//  reaction timer, false-start detection, best-of-N tracking. Sits between the
//  button edge detectors (single-cycle start/stop pulses) and the sseg driver,
//  whose glyph codes 0-9 digits, 10 'n', 11 'o', 12 '-' it emits directly.
// PARAMETERS
//  CLK_HZ           100_000_000  system clock frequency
//  TICK_HZ          1000         timer resolution (1 ms); DIV = CLK_HZ/TICK_HZ, integer, >=2
//  MIN_DELAY_TICKS  1000         fixed part of pre-delay, in ticks
//  DELAY_RAND_BITS  12           random part = LFSR[DELAY_RAND_BITS-1:0] ticks (<=16)
//  NUM_ROUNDS       5            valid rounds per session (>=1)
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  reset        in   1   synchronous, active-high
//  start_pulse  in   1   one-cycle start/re-arm request
//  stop_pulse   in   1   one-cycle player response
//  go_led       out  1   high while timer runs (GO state)
//  disp_code    out  16  {d3,d2,d1,d0} glyph codes to sseg
//  best_bcd     out  16  best valid time this session, BCD
//  round_idx    out  $clog2(NUM_ROUNDS+1)  valid rounds completed
//  false_start  out  1   high while in FALSE state
//  round_done   out  1   one-cycle pulse when a valid time is latched
//  session_done out  1   high in SUMMARY
// BEHAVIOUR
//  Reset (sync): state IDLE, go_led 0, disp_code {12,10,11,12}, best_bcd 16'h9999,
//   round_idx 0, flags 0, timer 0000, prescaler 0; LFSR <= 16'hACE1.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle incl. all states; never 0.
//  Prescaler: counts 0..DIV-1, tick = (cnt==DIV-1); runs only in ARMED/GO; cleared on
//   entry to either. Delay/timer counters change only on tick.
//  States: IDLE -> ARMED -> GO -> RESULT -> (ARMED | SUMMARY); ARMED -> FALSE -> ARMED.
//  IDLE: disp {12,10,11,12}. start_pulse: delay_cnt <= MIN_DELAY_TICKS + rand; -> ARMED.
//  ARMED: disp {12,12,12,12}; delay_cnt decrements per tick; on tick with delay_cnt==1
//   -> GO (go_led 1 next cycle, timer 0000). stop_pulse in ARMED -> FALSE (wins over tick).
//  FALSE: false_start 1, disp all 12, round not counted; start_pulse -> ARMED with new rand.
//  GO: disp = live timer; timer BCD-increments per tick, saturates at 9999 (no wrap).
//   stop_pulse: latch timer (same-cycle tick ignored), go_led 0, round_done 1 cycle,
//   round_idx+1, best_bcd <= min(best,time) (digit-wise BCD compare); -> RESULT.
//   Timer reaching 9999 without stop: latched as 9999, counted as a round; -> RESULT.
//  RESULT: disp = latched time. start_pulse: round_idx==NUM_ROUNDS -> SUMMARY else ARMED.
//   stop_pulse ignored.
//  SUMMARY: session_done 1, disp = best_bcd. start_pulse -> IDLE, round_idx 0, best 9999.
//  start_pulse in ARMED/GO ignored. start & stop same cycle: stop handled first per state
//   rules, start ignored except in IDLE/FALSE/RESULT/SUMMARY (where stop is ignored).
//  reset mid-operation: immediate return to reset values on next edge, any state.
//  Latency: stop_pulse at edge N -> go_led 0, disp frozen, round_done at N+1.
// STRUCTURE
//  Package reaction_pkg: state enum (IDLE,ARMED,GO,FALSE,RESULT,SUMMARY), glyph constants
//   GLYPH_N=10, GLYPH_O=11, GLYPH_DASH=12, LFSR_SEED, BCD_MAX=16'h9999.
//  Sub-module bcd_counter4: 4-digit BCD counter, clr/inc inputs, saturating at 9999,
//   outputs value and sat flag. FSM, prescaler, LFSR, best-compare stay in this module.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> DIV 10, MIN_DELAY_TICKS=5, DELAY_RAND_BITS=2,
//   NUM_ROUNDS=2)
//  reset 3 cycles -> disp 16'hCABC, best 16'h9999, go_led 0, round_idx 0.
//  start, stop 123 ticks after go_led rises -> disp 16'h0123, round_done 1 cycle, best 0123.
//  start, stop during ARMED -> false_start 1, disp 16'hCCCC, round_idx unchanged; start re-arms.
//  round 2 stop at 0087 -> best 0087, next start -> session_done 1, disp 16'h0087.
//  no stop for 10000 ticks -> timer holds 9999, RESULT, round counted.
//  reset asserted in GO -> next edge go_led 0, disp 16'hCABC, round_idx 0.

Source files
------------

// File: rtl/reaction_timer_multi_pkg.sv
// Shared types and constants for the reaction-time engine: FSM states, sseg glyphs,
// LFSR seed and a digit-wise BCD comparator.
package reaction_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, GO, FALSE, RESULT, SUMMARY} state_e;

  localparam logic [3:0]  GLYPH_N    = 4'd10;
  localparam logic [3:0]  GLYPH_O    = 4'd11;
  localparam logic [3:0]  GLYPH_DASH = 4'd12;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] BCD_MAX    = 16'h9999;

  // Most significant differing digit decides; equal values are not "less".
  function automatic logic bcd_lt(input logic [15:0] a, input logic [15:0] b);
    for (int i = 3; i >= 0; i--) begin
      if (a[i*4 +: 4] != b[i*4 +: 4]) return (a[i*4 +: 4] < b[i*4 +: 4]);
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/reaction_timer_multi_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, holding at 9999 instead of wrapping.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        inc_i,
  output logic [15:0] value_o,
  output logic        sat_o
);

  logic [15:0] val_q, val_d;

  assign value_o = val_q;
  assign sat_o   = (val_q == BCD_MAX);

  always_comb begin
    logic carry;
    val_d = val_q;
    carry = inc_i && !sat_o;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (val_q[i*4 +: 4] == 4'd9) begin
          val_d[i*4 +: 4] = 4'd0;
        end else begin
          val_d[i*4 +: 4] = val_q[i*4 +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (clr_i) val_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) val_q <= '0;
    else       val_q <= val_d;
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// Multi-round reaction-time engine: random pre-delay, GO lamp, BCD timer,
// false-start detection and best-of-session tracking, driving sseg glyph codes.
module reaction_timer_multi
  import reaction_pkg::*;
#(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 1000,
  parameter int MIN_DELAY_TICKS = 1000,
  parameter int DELAY_RAND_BITS = 12,
  parameter int NUM_ROUNDS      = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start_pulse,
  input  logic                                stop_pulse,
  output logic                                go_led,
  output logic [15:0]                         disp_code,
  output logic [15:0]                         best_bcd,
  output logic [$clog2(NUM_ROUNDS+1)-1:0]     round_idx,
  output logic                                false_start,
  output logic                                round_done,
  output logic                                session_done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(MIN_DELAY_TICKS + (1 << DELAY_RAND_BITS) + 1);
  localparam int RW  = $clog2(NUM_ROUNDS + 1);

  state_e          state_q, state_d;
  logic [15:0]     lfsr_q;
  logic [PW-1:0]   pre_q;
  logic [DW-1:0]   delay_q;
  logic [15:0]     best_q;
  logic [RW-1:0]   round_q;
  logic            round_done_q;
  logic            tick, load_delay, timer_clr, latch, clr_session;
  logic [15:0]     timer_val;
  logic            timer_sat;

  assign tick = ((state_q == ARMED) || (state_q == GO)) && (pre_q == PW'(DIV - 1));

  always_comb begin
    state_d     = state_q;
    load_delay  = 1'b0;
    timer_clr   = 1'b0;
    latch       = 1'b0;
    clr_session = 1'b0;
    case (state_q)
      IDLE:    if (start_pulse) begin state_d = ARMED; load_delay = 1'b1; end
      ARMED: begin
        // A response before GO always counts as a false start, even on the expiry tick.
        if (stop_pulse) state_d = FALSE;
        else if (tick && delay_q <= DW'(1)) begin state_d = GO; timer_clr = 1'b1; end
      end
      FALSE:   if (start_pulse) begin state_d = ARMED; load_delay = 1'b1; end
      GO:      if (stop_pulse || timer_sat) begin state_d = RESULT; latch = 1'b1; end
      RESULT: begin
        if (start_pulse) begin
          if (round_q == RW'(NUM_ROUNDS)) state_d = SUMMARY;
          else begin state_d = ARMED; load_delay = 1'b1; end
        end
      end
      SUMMARY: if (start_pulse) begin state_d = IDLE; clr_session = 1'b1; end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      pre_q        <= '0;
      delay_q      <= '0;
      best_q       <= BCD_MAX;
      round_q      <= '0;
      round_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      round_done_q <= latch;
      if (state_d != state_q)                        pre_q <= '0;
      else if (state_q == ARMED || state_q == GO)    pre_q <= tick ? '0 : pre_q + PW'(1);
      else                                           pre_q <= '0;
      if (load_delay)
        delay_q <= DW'(MIN_DELAY_TICKS) + DW'(lfsr_q[DELAY_RAND_BITS-1:0]);
      else if (state_q == ARMED && tick && !stop_pulse)
        delay_q <= delay_q - DW'(1);
      if (clr_session) begin
        round_q <= '0;
        best_q  <= BCD_MAX;
      end else if (latch) begin
        round_q <= round_q + RW'(1);
        if (bcd_lt(timer_val, best_q)) best_q <= timer_val;
      end
    end
  end

  // The timer only counts in GO, so it holds the latched time through RESULT.
  bcd_counter4 u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (timer_clr),
    .inc_i   ((state_q == GO) && tick && !stop_pulse),
    .value_o (timer_val),
    .sat_o   (timer_sat)
  );

  always_comb begin
    disp_code = {GLYPH_DASH, GLYPH_N, GLYPH_O, GLYPH_DASH};
    case (state_q)
      ARMED, FALSE: disp_code = {4{GLYPH_DASH}};
      GO, RESULT:   disp_code = timer_val;
      SUMMARY:      disp_code = best_q;
      default:      disp_code = {GLYPH_DASH, GLYPH_N, GLYPH_O, GLYPH_DASH};
    endcase
  end

  assign go_led       = (state_q == GO);
  assign false_start  = (state_q == FALSE);
  assign session_done = (state_q == SUMMARY);
  assign round_done   = round_done_q;
  assign round_idx    = round_q;
  assign best_bcd     = best_q;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench: one session on a DIV=10 instance, saturation on a fast DIV=2 instance.
module tb_reaction_timer_multi;

  logic        clk = 1'b0;
  logic        reset, start_pulse, stop_pulse;
  logic        go_led, false_start, round_done, session_done;
  logic [15:0] disp_code, best_bcd;
  logic [1:0]  round_idx;
  logic        reset2, start2, stop2;
  logic        go2, fs2, rd2, sd2;
  logic [15:0] disp2, best2;
  logic [1:0]  ridx2;
  int          checks = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  reaction_timer_multi #(.CLK_HZ(1000), .TICK_HZ(100), .MIN_DELAY_TICKS(5),
                         .DELAY_RAND_BITS(2), .NUM_ROUNDS(2)) dut (
    .clk(clk), .reset(reset), .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .go_led(go_led), .disp_code(disp_code), .best_bcd(best_bcd), .round_idx(round_idx),
    .false_start(false_start), .round_done(round_done), .session_done(session_done));

  reaction_timer_multi #(.CLK_HZ(1000), .TICK_HZ(500), .MIN_DELAY_TICKS(5),
                         .DELAY_RAND_BITS(2), .NUM_ROUNDS(2)) dut_fast (
    .clk(clk), .reset(reset2), .start_pulse(start2), .stop_pulse(stop2),
    .go_led(go2), .disp_code(disp2), .best_bcd(best2), .round_idx(ridx2),
    .false_start(fs2), .round_done(rd2), .session_done(sd2));

  task automatic pulse_start();
    start_pulse = 1'b1; @(negedge clk); start_pulse = 1'b0; @(negedge clk);
  endtask

  task automatic pulse_stop();
    stop_pulse = 1'b1; @(negedge clk); stop_pulse = 1'b0;
  endtask

  task automatic wait_go(input string name);
    int n = 0;
    while (!go_led && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (!go_led) $display("FAIL %s_go_timeout: go_led=%b want 1 within 200 cycles", name, go_led);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1; reset2 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0; reset2 = 1'b0;
    checks++; if (disp_code !== 16'hCABC) $display("FAIL rst_disp: got %h want CABC", disp_code); else passed++;
    checks++; if (best_bcd !== 16'h9999) $display("FAIL rst_best: got %h want 9999", best_bcd); else passed++;
    checks++; if (go_led !== 1'b0 || false_start !== 1'b0 || session_done !== 1'b0 || round_done !== 1'b0)
      $display("FAIL rst_flags: got go=%b fs=%b sd=%b rd=%b want 0", go_led, false_start, session_done, round_done);
    else passed++;
    checks++; if (round_idx !== 2'd0) $display("FAIL rst_round: got %0d want 0", round_idx); else passed++;
  endtask

  task automatic test_round1();
    pulse_start();
    checks++; if (disp_code !== 16'hCCCC) $display("FAIL armed_disp: got %h want CCCC", disp_code); else passed++;
    wait_go("r1");
    checks++; if (disp_code !== 16'h0000) $display("FAIL go_disp0: got %h want 0000", disp_code); else passed++;
    // Timer reads 123 from 1230 to 1239 cycles after entering GO.
    repeat (1234) @(negedge clk);
    pulse_stop();
    checks++; if (go_led !== 1'b0) $display("FAIL r1_go_off: got %b want 0", go_led); else passed++;
    checks++; if (round_done !== 1'b1) $display("FAIL r1_done: got %b want 1", round_done); else passed++;
    checks++; if (disp_code !== 16'h0123) $display("FAIL r1_disp: got %h want 0123", disp_code); else passed++;
    checks++; if (best_bcd !== 16'h0123) $display("FAIL r1_best: got %h want 0123", best_bcd); else passed++;
    checks++; if (round_idx !== 2'd1) $display("FAIL r1_round: got %0d want 1", round_idx); else passed++;
    repeat (20) @(negedge clk);
    checks++; if (round_done !== 1'b0) $display("FAIL r1_done_pulse: got %b want 0", round_done); else passed++;
    checks++; if (disp_code !== 16'h0123) $display("FAIL r1_hold: got %h want 0123", disp_code); else passed++;
  endtask

  task automatic test_false_start();
    pulse_start();
    repeat (3) @(negedge clk);
    pulse_stop();
    checks++; if (false_start !== 1'b1) $display("FAIL fs_flag: got %b want 1", false_start); else passed++;
    checks++; if (disp_code !== 16'hCCCC) $display("FAIL fs_disp: got %h want CCCC", disp_code); else passed++;
    checks++; if (round_idx !== 2'd1) $display("FAIL fs_round: got %0d want 1", round_idx); else passed++;
    checks++; if (round_done !== 1'b0) $display("FAIL fs_no_done: got %b want 0", round_done); else passed++;
    pulse_start();
    checks++; if (false_start !== 1'b0 || disp_code !== 16'hCCCC)
      $display("FAIL fs_rearm: got fs=%b disp=%h want fs=0 disp=CCCC", false_start, disp_code);
    else passed++;
  endtask

  task automatic test_round2_summary();
    wait_go("r2");
    repeat (874) @(negedge clk);
    pulse_stop();
    checks++; if (disp_code !== 16'h0087) $display("FAIL r2_disp: got %h want 0087", disp_code); else passed++;
    checks++; if (best_bcd !== 16'h0087) $display("FAIL r2_best: got %h want 0087", best_bcd); else passed++;
    checks++; if (round_idx !== 2'd2 || round_done !== 1'b1)
      $display("FAIL r2_round: got idx=%0d rd=%b want idx=2 rd=1", round_idx, round_done);
    else passed++;
    pulse_start();
    checks++; if (session_done !== 1'b1) $display("FAIL sum_flag: got %b want 1", session_done); else passed++;
    checks++; if (disp_code !== 16'h0087) $display("FAIL sum_disp: got %h want 0087", disp_code); else passed++;
    pulse_start();
    checks++; if (disp_code !== 16'hCABC || session_done !== 1'b0)
      $display("FAIL idle_again: got disp=%h sd=%b want CABC 0", disp_code, session_done);
    else passed++;
    checks++; if (round_idx !== 2'd0 || best_bcd !== 16'h9999)
      $display("FAIL session_clear: got idx=%0d best=%h want 0 9999", round_idx, best_bcd);
    else passed++;
  endtask

  task automatic test_reset_in_go();
    pulse_start();
    wait_go("rst");
    repeat (25) @(negedge clk);
    checks++; if (disp_code !== 16'h0002) $display("FAIL rst_pre_timer: got %h want 0002", disp_code); else passed++;
    reset = 1'b1; @(negedge clk);
    checks++; if (go_led !== 1'b0 || disp_code !== 16'hCABC || round_idx !== 2'd0)
      $display("FAIL rst_in_go: got go=%b disp=%h idx=%0d want 0 CABC 0", go_led, disp_code, round_idx);
    else passed++;
    reset = 1'b0; @(negedge clk);
  endtask

  task automatic test_saturate();
    int n = 0;
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    while (!go2 && n < 200) begin @(negedge clk); n++; end
    checks++; if (!go2) $display("FAIL sat_go_timeout: go=%b want 1", go2); else passed++;
    n = 0;
    while (go2 && n < 25000) begin @(negedge clk); n++; end
    checks++; if (go2 !== 1'b0) $display("FAIL sat_timeout: go=%b want 0 within 25000 cycles", go2); else passed++;
    checks++; if (disp2 !== 16'h9999 || rd2 !== 1'b1 || ridx2 !== 2'd1)
      $display("FAIL sat_result: got disp=%h rd=%b idx=%0d want 9999 1 1", disp2, rd2, ridx2);
    else passed++;
    repeat (30) @(negedge clk);
    checks++; if (disp2 !== 16'h9999 || best2 !== 16'h9999)
      $display("FAIL sat_hold: got disp=%h best=%h want 9999 9999", disp2, best2);
    else passed++;
  endtask

  initial begin
    start_pulse = 1'b0; stop_pulse = 1'b0; start2 = 1'b0; stop2 = 1'b0;
    reset = 1'b1; reset2 = 1'b1;
    @(negedge clk);
    test_reset();
    test_round1();
    test_false_start();
    test_round2_summary();
    test_reset_in_go();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
